y_demux2_buf: RTL and testbench

Y_DEMUX2_BUF -- requirements
Module: y_demux2_buf

---
 rtl/y_defs.sv | 8 +
 rtl/y_fifo.sv | 65 ++++++
 rtl/y_demux2_buf.sv | 70 +++++++
 tb/tb_y_demux2_buf.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/y_defs.sv
// Shared constants for the y_* demux/buffer blocks.
// PORT_A/PORT_B give the meaning of the destination select bit.
package y_defs;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/y_fifo.sv
// Single-port-pair FIFO buffer: one writer (push), one reader (pop), power-of-two depth.
// Head word is presented on o_data; o_data reads 0 whenever the buffer is empty.
module y_fifo #(
  parameter int SIZE  = 2,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [SIZE-1:0]            i_data,
  input  logic                       i_pop,
  output logic                       o_valid,
  output logic [SIZE-1:0]            o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [SIZE-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A full buffer refuses a push even when it pops on the same edge; an
  // empty buffer cannot pop, so a fresh word always waits one cycle.
  assign w_push = i_push & ~w_full;
  assign w_pop  = i_pop & ~w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: data is masked by the empty flag.
  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wptr] <= i_data;
  end

  assign o_valid = ~w_empty;
  assign o_data  = w_empty ? '0 : r_mem[r_rptr];
  assign o_count = r_count;
  assign o_full  = w_full;

endmodule

// File: rtl/y_demux2_buf.sv
// 1-to-2 demultiplexer with an independent FIFO behind each output port.
// Top level only steers the input word and derives the input ready.
module y_demux2_buf
  import y_defs::*;
#(
  parameter int SIZE  = 2,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SIZE-1:0]            in_data,
  input  logic                       in_sel,
  output logic                       a_valid,
  input  logic                       a_ready,
  output logic [SIZE-1:0]            a_data,
  output logic [$clog2(DEPTH+1)-1:0] a_count,
  output logic                       b_valid,
  input  logic                       b_ready,
  output logic [SIZE-1:0]            b_data,
  output logic [$clog2(DEPTH+1)-1:0] b_count
);

  // Handshake: a word moves on a rising clk edge exactly when its valid and
  // ready are both 1; valid never waits on ready, and in_ready depends only
  // on in_sel and the selected buffer's fullness.

  logic w_a_full;
  logic w_b_full;
  logic w_fire;
  logic w_push_a;
  logic w_push_b;

  assign in_ready = (in_sel == PORT_B) ? ~w_b_full : ~w_a_full;
  assign w_fire   = in_valid & in_ready;
  assign w_push_a = w_fire & (in_sel == PORT_A);
  assign w_push_b = w_fire & (in_sel == PORT_B);

  y_fifo #(
    .SIZE  (SIZE),
    .DEPTH (DEPTH)
  ) u_fifo_a (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push_a),
    .i_data  (in_data),
    .i_pop   (a_ready),
    .o_valid (a_valid),
    .o_data  (a_data),
    .o_count (a_count),
    .o_full  (w_a_full)
  );

  y_fifo #(
    .SIZE  (SIZE),
    .DEPTH (DEPTH)
  ) u_fifo_b (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push_b),
    .i_data  (in_data),
    .i_pop   (b_ready),
    .o_valid (b_valid),
    .o_data  (b_data),
    .o_count (b_count),
    .o_full  (w_b_full)
  );

endmodule

// File: tb/tb_y_demux2_buf.sv
// Bench for y_demux2_buf: queue-based model per port, one compare process on
// every falling edge, plus literal expectations from the directed scenarios.
module tb_y_demux2_buf;

  localparam int SIZE  = 2;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] in_data;
  logic            in_sel;
  logic            a_valid;
  logic            a_ready;
  logic [SIZE-1:0] a_data;
  logic [CW-1:0]   a_count;
  logic            b_valid;
  logic            b_ready;
  logic [SIZE-1:0] b_data;
  logic [CW-1:0]   b_count;

  int checks = 0;
  int errors = 0;

  y_demux2_buf #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .a_count  (a_count),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data),
    .b_count  (b_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  logic [SIZE-1:0] exp_qa[$];
  logic [SIZE-1:0] exp_qb[$];
  bit model_live = 0;

  always @(posedge clk) begin
    if (rst) begin
      exp_qa.delete();
      exp_qb.delete();
      model_live = 1;
    end else if (model_live) begin
      bit acc;
      acc = in_valid && ((in_sel ? exp_qb.size() : exp_qa.size()) < DEPTH);
      if (a_ready && exp_qa.size() > 0) void'(exp_qa.pop_front());
      if (b_ready && exp_qb.size() > 0) void'(exp_qb.pop_front());
      if (acc) begin
        if (in_sel) exp_qb.push_back(in_data);
        else        exp_qa.push_back(in_data);
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("a_valid", a_valid, exp_qa.size() != 0);
      chk("a_data",  a_data,  exp_qa.size() != 0 ? exp_qa[0] : '0);
      chk("a_count", a_count, exp_qa.size());
      chk("b_valid", b_valid, exp_qb.size() != 0);
      chk("b_data",  b_data,  exp_qb.size() != 0 ? exp_qb[0] : '0);
      chk("b_count", b_count, exp_qb.size());
      chk("in_ready", in_ready,
          (in_sel ? exp_qb.size() : exp_qa.size()) < DEPTH);
    end
  end

  // ---------------- driver ----------------
  initial begin
    int pa;
    int pb;
    int guard;
    rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    a_ready = 1'b0; b_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_a_valid", a_valid, 0);
    chk("rst_a_count", a_count, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_in_ready", in_ready, 1);

    // single word to A, visible next cycle
    tick();
    in_valid = 1'b1; in_sel = 1'b0; in_data = 2'b10;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_a_valid", a_valid, 1);
    chk("t1_a_data",  a_data,  2'b10);
    chk("t1_a_count", a_count, 1);
    chk("t1_b_valid", b_valid, 0);
    tick();
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    @(negedge clk);
    chk("t1_a_drained", a_count, 0);

    // fill B with b_ready low, then try a third word
    tick();
    in_valid = 1'b1; in_sel = 1'b1; in_data = 2'b01;
    tick();
    in_data = 2'b11;
    tick();
    in_data = 2'b10;
    @(negedge clk);
    chk("t2_b_count", b_count, 2);
    chk("t2_ready_b", in_ready, 0);
    chk("t2_b_data",  b_data,  2'b01);
    in_sel = 1'b0;
    #1;
    chk("t2_ready_a", in_ready, 1);
    in_sel = 1'b1;
    b_ready = 1'b1;
    // full B pops while the push is refused
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t3_b_data1",  b_data,  2'b11);
    chk("t3_b_count1", b_count, 1);
    tick();
    @(negedge clk);
    chk("t3_b_count0", b_count, 0);
    chk("t3_b_valid0", b_valid, 0);
    chk("t3_b_data0",  b_data,  0);

    // interleaved routing, both consumers always ready
    tick();
    a_ready = 1'b1; b_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_sel = i[0]; in_data = i[SIZE-1:0];
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      if (i[0]) begin
        chk("t4_b_data",  b_data,  i);
        chk("t4_a_valid", a_valid, 0);
      end else begin
        chk("t4_a_data",  a_data,  i);
        chk("t4_b_valid", b_valid, 0);
      end
      tick();
    end

    // mid-stream reset discards A and blocks a same-edge push to B
    a_ready = 1'b0; b_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 2'b01;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_a_count1", a_count, 1);
    tick();
    rst = 1'b1; in_valid = 1'b1; in_sel = 1'b1; in_data = 2'b11;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("t5_a_valid", a_valid, 0);
    chk("t5_a_count", a_count, 0);
    chk("t5_a_data",  a_data,  0);
    chk("t5_b_count", b_count, 0);
    tick();
    in_valid = 1'b1; in_sel = 1'b0; in_data = 2'b11;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_after_push", a_data, 2'b11);

    // sweep every data value to both ports with random consumer stalls
    tick();
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_sel = k[2]; in_data = k[1:0];
      a_ready = 1'($urandom_range(0, 1)); b_ready = 1'($urandom_range(0, 1));
      #1;
      guard = 0;
      while (!in_ready && guard < 50) begin
        tick();
        a_ready = 1'($urandom_range(0, 1)); b_ready = 1'($urandom_range(0, 1));
        #1;
        guard++;
      end
      chk("sweep_accept_timeout", guard < 50, 1);
      tick();
      in_valid = 1'b0;
    end

    // long random run with phase-varying consumer pressure
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) begin
        pa = $urandom_range(10, 95);
        pb = $urandom_range(10, 95);
      end
      rst      = ($urandom_range(0, 299) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_sel   = 1'($urandom_range(0, 1));
      in_data  = SIZE'($urandom_range(0, 3));
      a_ready  = ($urandom_range(0, 99) < pa);
      b_ready  = ($urandom_range(0, 99) < pb);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
